// File: rtl/lfsr_operand_gen_pkg.sv
// Shared types and constants for the LFSR operand generator.
package lfsr_operand_pkg;

    // Draw sequencer states; Busy is asserted in every state except IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW_A = 2'd1,
        DRAW_B = 2'd2
    } draw_state_e;

    // Known maximal-length Galois feedback masks.
    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;

endpackage

// File: rtl/lfsr_operand_gen_galois.sv
// Free-running Galois LFSR with seed loading and lock-up protection.
module lfsr_galois #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Seed_Load,
    input  logic [WIDTH-1:0] Seed_In,
    output logic [WIDTH-1:0] State
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] step;

    // Next state: seed load wins over the step; a zero seed or a zero state
    // would lock the register up, so both fall back to SEED.
    always_comb begin
        step    = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        state_d = step;
        if (Seed_Load) begin
            state_d = (Seed_In == '0) ? SEED : Seed_In;
        end else if (state_q == '0) begin
            state_d = SEED;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign State = state_q;

endmodule

// File: rtl/lfsr_operand_gen.sv
// Operand generator: draws two operands bounded by a runtime maximum from a
// free-running LFSR, using rejection sampling and a Req/Busy/Valid handshake.
module lfsr_operand_gen
    import lfsr_operand_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Seed_Load,
    input  logic [WIDTH-1:0] Seed_In,
    input  logic             Req,
    input  logic [WIDTH-1:0] Max_Value,
    output logic             Busy,
    output logic             Valid,
    output logic [WIDTH-1:0] Operand_A,
    output logic [WIDTH-1:0] Operand_B
);

    draw_state_e      state_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             valid_q;

    logic [WIDTH-1:0] lfsr_state;
    logic [WIDTH-1:0] candidate;
    logic             accept;

    lfsr_galois #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .Clock     (Clock),
        .Reset     (Reset),
        .Seed_Load (Seed_Load),
        .Seed_In   (Seed_In),
        .State     (lfsr_state)
    );

    // LFSR never holds zero, so lfsr-1 spans 0..2^WIDTH-2 uniformly.
    assign candidate = lfsr_state - WIDTH'(1);
    assign accept    = (candidate <= max_q);

    // Draw sequencer: accept Req when idle, then sample A and B, rejecting
    // candidates above the captured maximum; Valid pulses on B acceptance.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            max_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Req) begin
                        max_q   <= Max_Value;
                        state_q <= DRAW_A;
                    end
                end
                DRAW_A: begin
                    if (accept) begin
                        a_q     <= candidate;
                        state_q <= DRAW_B;
                    end
                end
                DRAW_B: begin
                    if (accept) begin
                        b_q     <= candidate;
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Valid     = valid_q;
    assign Operand_A = a_q;
    assign Operand_B = b_q;

endmodule
